// File: rtl/mem_pkg.sv
// Shared memory-hierarchy package.
// Holds the default geometry used by the cache controller and the backing RAM,
// so both sides agree on address and word widths without repeating literals.
package mem_pkg;

  // Default RAM geometry: 32 words of 3 bits.
  localparam int unsigned RAM_ADDR_W = 5;
  localparam int unsigned RAM_DATA_W = 3;
  localparam int unsigned RAM_DEPTH  = 2 ** RAM_ADDR_W;

endpackage

// File: rtl/ram.sv
// Single-port RAM with registered, write-first read data.
// Storage is built from reset-initialised flip-flops. While reset is high,
// word i holds i modulo 2**DATA_W.
//
// Ports (positional order matters for legacy instantiations):
//   address  - word address for read and write
//   clock    - single clock, rising edge
//   data_in  - write data
//   write    - 1 = write, 0 = read
//   data_out - registered read data, one-cycle latency
//   reset    - asynchronous, active-high; clears data_out and preloads memory
module ram
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W,
  parameter int unsigned DEPTH  = RAM_DEPTH
) (
  input  logic [ADDR_W-1:0] address,
  input  logic              clock,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write,
  output logic [DATA_W-1:0] data_out,
  input  logic              reset
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_q;

  // Reset has priority, so a write coinciding with reset is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else if (write) begin
      mem_q[address] <= data_in;
      data_q         <= data_in;
    end else begin
      data_q <= mem_q[address];
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: a table of directed vectors, hand-written
// sequences for reset and timing corners, then randomised traffic checked
// against an array model of the memory.
module tb_ram;

  logic [4:0] address;
  logic       clock;
  logic [2:0] data_in;
  logic       write;
  logic [2:0] data_out;
  logic       reset;

  logic clk_run;
  int   n_checks;
  int   n_fail;

  // Behavioural model: plain array, reset value is index mod 8.
  logic [2:0] ref_mem [32];

  typedef struct {
    logic       w;
    logic [4:0] a;
    logic [2:0] d;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs [15];

  ram dut (
    .address  (address),
    .clock    (clock),
    .data_in  (data_in),
    .write    (write),
    .data_out (data_out),
    .reset    (reset)
  );

  // Gated free-running clock, period 10, so reset can be applied while stopped.
  initial begin
    clock = 1'b0;
    forever begin
      #5;
      if (clk_run) clock = ~clock;
    end
  end

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = 3'(i % 8);
  endtask

  // One operation: inputs driven at the falling edge, result sampled 1 after
  // the rising edge. Optionally scrambles the inputs between edges.
  task automatic do_op(input logic w, input logic [4:0] a, input logic [2:0] d,
                       input bit glitch, output logic [2:0] exp);
    @(negedge clock);
    write   = w;
    address = a;
    data_in = d;
    if (w) begin
      ref_mem[a] = d;
      exp        = d;
    end else begin
      exp = ref_mem[a];
    end
    @(posedge clock);
    #1;
    if (glitch) begin
      write   = ~w;
      address = ~a;
      data_in = ~d;
    end
  endtask

  // Stop the clock low, assert reset, check data_out clears with no edge.
  task automatic reset_clock_stopped();
    @(negedge clock);
    clk_run = 1'b0;
    write   = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_data_out", data_out, 3'd0);
    model_reset();
    #5;
    reset = 1'b0;
    #1;
    clk_run = 1'b1;
  endtask

  initial begin
    logic [2:0] e;
    logic [4:0] ai;
    logic [2:0] inv;

    n_checks = 0;
    n_fail   = 0;
    clk_run  = 1'b1;
    reset    = 1'b1;
    write    = 1'b0;
    address  = '0;
    data_in  = '0;
    model_reset();

    repeat (2) @(posedge clock);
    #1;
    check("reset_held_data_out", data_out, 3'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed vectors from the reset image.
    vecs[0]  = '{1'b0, 5'd13, 3'd0, 3'd5};
    vecs[1]  = '{1'b0, 5'd0,  3'd0, 3'd0};
    vecs[2]  = '{1'b0, 5'd31, 3'd0, 3'd7};
    vecs[3]  = '{1'b0, 5'd5,  3'd0, 3'd5};
    vecs[4]  = '{1'b0, 5'd9,  3'd0, 3'd1};
    vecs[5]  = '{1'b1, 5'd7,  3'd6, 3'd6};
    vecs[6]  = '{1'b0, 5'd7,  3'd0, 3'd6};
    vecs[7]  = '{1'b0, 5'd6,  3'd0, 3'd6};
    vecs[8]  = '{1'b1, 5'd20, 3'd3, 3'd3};
    vecs[9]  = '{1'b0, 5'd20, 3'd0, 3'd3};
    vecs[10] = '{1'b0, 5'd21, 3'd0, 3'd5};
    vecs[11] = '{1'b1, 5'd7,  3'd1, 3'd1};
    vecs[12] = '{1'b1, 5'd7,  3'd2, 3'd2};
    vecs[13] = '{1'b0, 5'd7,  3'd0, 3'd2};
    vecs[14] = '{1'b0, 5'd20, 3'd0, 3'd3};
    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].w, vecs[i].a, vecs[i].d, 1'b0, e);
      check($sformatf("vec%0d", i), data_out, vecs[i].exp);
    end

    // Reset with the clock stopped, then read address 13.
    do_op(1'b1, 5'd1, 3'd3, 1'b0, e);
    check("pre_reset_write_first", data_out, 3'd3);
    reset_clock_stopped();
    do_op(1'b0, 5'd13, 3'd0, 1'b0, e);
    check("post_reset_read13", data_out, 3'd5);
    do_op(1'b0, 5'd1, 3'd0, 1'b0, e);
    check("post_reset_read1_restored", data_out, 3'd1);

    // Controller timing: read held two edges, then write held two edges.
    do_op(1'b0, 5'd9, 3'd0, 1'b0, e);
    check("ctl_read9_edge1", data_out, 3'd1);
    do_op(1'b0, 5'd9, 3'd0, 1'b0, e);
    check("ctl_read9_edge2", data_out, 3'd1);
    do_op(1'b1, 5'd9, 3'd4, 1'b0, e);
    do_op(1'b1, 5'd9, 3'd4, 1'b0, e);
    check("ctl_write9_held", data_out, 3'd4);
    do_op(1'b0, 5'd9, 3'd0, 1'b0, e);
    check("ctl_read9_after_write", data_out, 3'd4);

    // Reset pulsed around an edge with a write pending: write must be lost.
    @(negedge clock);
    write   = 1'b1;
    address = 5'd2;
    data_in = 3'd7;
    #3;
    reset = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    check("midop_reset_data_out", data_out, 3'd0);
    model_reset();
    do_op(1'b0, 5'd2, 3'd0, 1'b0, e);
    check("midop_reset_mem2", data_out, 3'd2);

    // Sweep: write inverted low bits everywhere, then read all back.
    for (int i = 0; i < 32; i++) begin
      ai  = 5'(i);
      inv = ~ai[2:0];
      do_op(1'b1, ai, inv, 1'b0, e);
      check($sformatf("sweep_wr%0d", i), data_out, inv);
    end
    for (int i = 0; i < 32; i++) begin
      ai  = 5'(i);
      inv = ~ai[2:0];
      do_op(1'b0, ai, 3'd0, 1'b0, e);
      check($sformatf("sweep_rd%0d", i), data_out, inv);
    end

    // Random traffic with inputs scrambled between edges.
    for (int i = 0; i < 400; i++) begin
      do_op(1'($urandom_range(0, 2) == 0), 5'($urandom), 3'($urandom), 1'b1, e);
      check($sformatf("rand%0d", i), data_out, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 Parameter ADDR_W, default 5, address width in bits.
REQ-002 Parameter DATA_W, default 3, data word width in bits.
REQ-003 Parameter DEPTH, default 32 (2**ADDR_W), number of words.
REQ-004 Port clock  input  1  single clock; all state changes on its rising edge except reset.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port address  input  ADDR_W  word address for read and write.
REQ-007 Port data_in  input  DATA_W  write data.
REQ-008 Port write  input  1  write enable; 1 = write, 0 = read.
REQ-009 Port data_out  output  DATA_W  registered read data.
REQ-010 Positional port order SHALL be address, clock, data_in, write, data_out, reset, so existing four-signal-plus-output positional instantiations keep their order.
REQ-011 Clocking and reset: one clock; reset is asynchronous and active-high.

Function
REQ-012 Storage SHALL be DEPTH words of DATA_W bits, single port, addressed by the full address value; every 5-bit address is valid (0..31), no wrap or out-of-range case.
REQ-013 On a rising clock edge with write=1 and reset=0, mem[address] SHALL take data_in.
REQ-014 On the same edge with write=1, data_out SHALL take data_in (write-first); with write=0, data_out SHALL take mem[address] as it was before the edge.
REQ-015 Read latency SHALL be exactly one clock: an address presented before edge N yields its data on data_out after edge N, stable until the next edge.
REQ-016 A write at edge N SHALL be visible to a read of the same address presented before edge N+1 (data_out valid after edge N+1).
REQ-017 write held high on consecutive edges SHALL rewrite the current address each edge; no side effect beyond the stored value.
REQ-018 Address, data_in and write are sampled only at the rising edge; changes between edges SHALL NOT affect memory or data_out.
REQ-019 Memory contents SHALL be held indefinitely while write=0.
REQ-020 No combinational path from any input to data_out.

Reset
REQ-021 While reset=1, data_out SHALL be 0 immediately (asynchronous) and every mem[i] SHALL be i modulo 2**DATA_W (word 0=0, 5=5, 9=1, 31=7).
REQ-022 While reset=1, write SHALL be ignored.
REQ-023 Reset asserted mid-operation SHALL abort any write on that edge; the first edge after deassertion SHALL operate normally per REQ-013/014.

Structure
REQ-024 ADDR_W, DATA_W and DEPTH defaults SHALL live in the shared memory-hierarchy package (mem_pkg) used by the cache controller and RAM; no typedefs required.
REQ-025 Single module, no sub-modules; array as flip-flops (reset-initialised), not an inferred macro.

Verification
REQ-026 Reset: assert reset with clock stopped -> data_out=0 at once; release, read address 13 -> data_out=5 one edge later.
REQ-027 Write then read: write 3'b110 to address 7 at edge N, read address 7 -> data_out=6 after edge N+1; address 6 still reads 6 (reset value).
REQ-028 Write-first: write 3'b011 to address 20 -> data_out=3 after the same edge.
REQ-029 Controller timing: address=9, write=0 set at edge N, sample data_out at edge N+2 -> 1; then write=1, address=9, data_in=4 held two edges, then read -> 4.
REQ-030 Mid-op reset: write=1, address=2, data_in=7 with reset pulsed around the edge -> mem[2] stays 2, data_out=0.
REQ-031 Sweep: write ~i[2:0] to all 32 addresses, read back all 32 -> each equals ~i[2:0], one-cycle latency throughout.
